stage_mem_pipe: RTL

Parametrised pipeline memory stage: accepts one load/store per instruction from the execute/memory pipeline register, formats it and runs a single Wishbone classic master cycle. It stalls the pipeline while the bus is busy and returns sign/zero-extended load data. It also reports misalignment, bus-error and timeout exceptions as registered one-cycle pulses. It sits between the execute stage and writeback and supports RV32 and RV64 widths.

---
 rtl/stage_mem_pkg.sv | 19 +
 rtl/stage_mem_pipe_fmt.sv | 42 ++++
 rtl/stage_mem_pipe.sv | 131 +++++++++++++
 3 files changed

// File: rtl/stage_mem_pkg.sv
// stage_mem_pkg: shared funct3 codes, FSM states and lane-width helpers for the memory stage
package stage_mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  localparam int NB_MAX = 8;
  localparam int OW_MAX = $clog2(NB_MAX);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  function automatic int nb_of(input int xlen);
    return xlen / 8;
  endfunction
  function automatic int ow_of(input int xlen);
    return $clog2(xlen / 8);
  endfunction
endpackage

// File: rtl/stage_mem_pipe_fmt.sv
// lsu_fmt: combinational store lane/sel formatting, load extract/extend, legality and alignment
module lsu_fmt
  import stage_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 we,
  input  logic [2:0]           funct3,
  input  logic [OW_MAX-1:0]    addr_lo,
  input  logic [XLEN-1:0]      st_data,
  input  logic [XLEN-1:0]      bus_data,
  output logic                 legal,
  output logic                 aligned,
  output logic [XLEN/8-1:0]    sel,
  output logic [XLEN-1:0]      st_lanes,
  output logic [XLEN-1:0]      ld_data
);
  localparam int NB = nb_of(XLEN);
  localparam int OW = ow_of(XLEN);
  localparam int MW = 2 * NB;
  localparam logic W64 = XLEN == 64;
  logic [1:0] size;
  logic [3:0] bytes;
  logic [OW-1:0] off;
  logic [XLEN-1:0] shifted;
  int msb;
  assign size = funct3[1:0];
  assign bytes = 4'd1 << size;
  assign off = addr_lo[OW-1:0];
  // unsigned codes exist only for loads, and only up to word width
  assign legal = funct3[2] ? (~we & (size < 2'd2 | (size == 2'd2 & W64))) : (size != 2'd3 | W64);
  assign aligned = (addr_lo & 3'(bytes - 4'd1)) == 3'd0;
  assign sel = NB'(MW'((9'd1 << bytes) - 9'd1) << off);
  assign shifted = bus_data >> {off, 3'b000};
  always_comb begin
    msb = (int'(bytes) * 8 > XLEN ? XLEN : int'(bytes) * 8) - 1;
    st_lanes = '0;
    ld_data = '0;
    for (int i = 0; i < NB; i++) st_lanes[8*i +: 8] = st_data[8*(i & (int'(bytes) - 1)) +: 8];
    for (int j = 0; j < XLEN; j++) ld_data[j] = j <= msb ? shifted[j] : ~funct3[2] & shifted[msb];
  end
endmodule

// File: rtl/stage_mem_pipe.sv
// stage_mem_pipe: pipeline memory stage running one Wishbone classic cycle per load/store
module stage_mem_pipe
  import stage_mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  input  logic                req_we_i,
  input  logic [2:0]          funct3_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [XLEN-1:0]     st_data_i,
  input  logic                flush_i,
  output logic [XLEN-1:0]     ld_data_o,
  output logic                done_o,
  output logic                stall_o,
  output logic                e_ld_addr_mis_o,
  output logic                e_st_addr_mis_o,
  output logic                e_ld_fault_o,
  output logic                e_st_fault_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [XLEN/8-1:0]   wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_addr_o,
  output logic [XLEN-1:0]     wbm_dat_o,
  input  logic [XLEN-1:0]     wbm_dat_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i
);
  localparam int NB = nb_of(XLEN);
  localparam int OW = ow_of(XLEN);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state;
  logic [TW-1:0] tcnt;
  logic killed, we_q, legal, aligned, idle, kill, fault, to_hit;
  logic [2:0] f3_q;
  logic [OW_MAX-1:0] lo_q;
  logic [NB-1:0] sel;
  logic [XLEN-1:0] st_lanes, ld_fmt;
  assign idle = state == IDLE;
  assign stall_o = req_valid_i & (state != DONE);
  assign to_hit = TIMEOUT != 0 && tcnt == TW'(TIMEOUT);
  assign kill = killed | flush_i;
  assign fault = wbm_err_i | (~wbm_ack_i & to_hit);
  // the formatter checks the live request in IDLE and decodes the latched one afterwards
  lsu_fmt #(.XLEN(XLEN)) u_fmt (
    .we       (idle ? req_we_i : we_q),
    .funct3   (idle ? funct3_i : f3_q),
    .addr_lo  (idle ? addr_i[OW_MAX-1:0] : lo_q),
    .st_data  (st_data_i),
    .bus_data (wbm_dat_i),
    .legal    (legal),
    .aligned  (aligned),
    .sel      (sel),
    .st_lanes (st_lanes),
    .ld_data  (ld_fmt)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      tcnt <= '0;
      killed <= 1'b0;
      we_q <= 1'b0;
      f3_q <= '0;
      lo_q <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o <= 1'b0;
      wbm_sel_o <= '0;
      wbm_addr_o <= '0;
      wbm_dat_o <= '0;
      ld_data_o <= '0;
      done_o <= 1'b0;
      e_ld_addr_mis_o <= 1'b0;
      e_st_addr_mis_o <= 1'b0;
      e_ld_fault_o <= 1'b0;
      e_st_fault_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      e_ld_addr_mis_o <= 1'b0;
      e_st_addr_mis_o <= 1'b0;
      e_ld_fault_o <= 1'b0;
      e_st_fault_o <= 1'b0;
      case (state)
        IDLE: if (req_valid_i && !flush_i) begin
          we_q <= req_we_i;
          f3_q <= funct3_i;
          lo_q <= addr_i[OW_MAX-1:0];
          ld_data_o <= '0;
          if (legal && aligned) begin
            state <= BUS;
            tcnt <= '0;
            killed <= 1'b0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o <= req_we_i;
            wbm_sel_o <= sel;
            wbm_addr_o <= {addr_i[ADDR_W-1:OW], {OW{1'b0}}};
            wbm_dat_o <= st_lanes;
          end else begin
            state <= DONE;
            done_o <= 1'b1;
            e_ld_addr_mis_o <= legal & ~req_we_i;
            e_st_addr_mis_o <= legal & req_we_i;
          end
        end
        BUS: begin
          killed <= kill;
          if (wbm_ack_i || wbm_err_i || to_hit) begin
            state <= DONE;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            done_o <= ~kill;
            e_ld_fault_o <= ~kill & fault & ~we_q;
            e_st_fault_o <= ~kill & fault & we_q;
            ld_data_o <= (fault || we_q || kill) ? '0 : ld_fmt;
          end else if (TIMEOUT != 0) tcnt <= tcnt + 1'b1;
        end
        DONE: begin
          state <= IDLE;
          killed <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
